// File: rtl/mod_bit_sequencer.sv
// mod_bit_sequencer: symbol-timing controller for the modulator datapath.
// A programmable divider sets the symbol period (div_reg+1 clk cycles, latched
// when a stream starts); data words arrive over valid/ready and are sent
// MSB-first, one symbol per period, back-to-back without gap symbols.
// Optional build macro: MOD_BIT_SEQUENCER_PREAMBLE_EN prefixes every stream
// with PRE_LEN alternating 1,0,1,0... symbols.
//
// Handshake: a word transfers on every cycle where din_valid & din_ready.
// din_ready never depends on din_valid; din_valid may be held or dropped freely.
module mod_bit_sequencer #(
    parameter int DIV_W   = 12,
    parameter int DATA_W  = 8,
    parameter int PRE_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_val,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              bit_out,
    output logic              bit_strobe,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
    localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam logic [PW-1:0] LAST_PRE = PW'(PRE_LEN - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, SHIFT = 2'd2} state_t;
    logic [PW-1:0] pre_cnt, pre_cnt_n;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd2} state_t;
`endif

    state_t            state, state_n;
    logic [DIV_W-1:0]  cnt, cnt_n;
    logic [DIV_W-1:0]  div_reg, div_reg_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] pend_word, pend_word_n;
    logic              pend_valid, pend_valid_n;
    logic              strobe_n, done_n;
    logic              tick, xfer;

    // Ready in IDLE, or during the last bit of a word while the pending slot is empty.
    assign din_ready = rst & en & ((state == IDLE) |
                       ((state == SHIFT) & (bitcnt == LAST_BIT) & ~pend_valid));
    assign xfer = din_valid & din_ready;
    assign tick = (state != IDLE) & (cnt == div_reg);
    assign busy = (state != IDLE);

    // Serial symbol decoded from state: data MSB in SHIFT, alternating pattern in PRE, 0 otherwise.
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
    assign bit_out = ((state == SHIFT) & shreg[DATA_W-1]) | ((state == PRE) & ~pre_cnt[0]);
`else
    assign bit_out = (state == SHIFT) & shreg[DATA_W-1];
`endif

    // Next-state and datapath update; en low overrides ticks and acceptances.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        div_reg_n    = div_reg;
        bitcnt_n     = bitcnt;
        shreg_n      = shreg;
        pend_word_n  = pend_word;
        pend_valid_n = pend_valid;
        strobe_n     = 1'b0;
        done_n       = 1'b0;
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
        pre_cnt_n    = pre_cnt;
`endif
        if (!en) begin
            state_n      = IDLE;
            cnt_n        = '0;
            bitcnt_n     = '0;
            pend_valid_n = 1'b0;
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
            pre_cnt_n    = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg_n   = din;
                        div_reg_n = div_val;
                        cnt_n     = '0;
                        bitcnt_n  = '0;
                        strobe_n  = 1'b1;
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
                        pre_cnt_n = '0;
                        state_n   = PRE;
`else
                        state_n   = SHIFT;
`endif
                    end
                end
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
                PRE: begin
                    cnt_n = tick ? '0 : cnt + DIV_W'(1);
                    if (tick) begin
                        strobe_n = 1'b1;
                        if (pre_cnt == LAST_PRE) begin
                            state_n = SHIFT;
                        end else begin
                            pre_cnt_n = pre_cnt + PW'(1);
                        end
                    end
                end
`endif
                SHIFT: begin
                    cnt_n = tick ? '0 : cnt + DIV_W'(1);
                    if (tick) begin
                        strobe_n = 1'b1;
                        if (bitcnt != LAST_BIT) begin
                            shreg_n  = {shreg[DATA_W-2:0], 1'b0};
                            bitcnt_n = bitcnt + BW'(1);
                        end else if (pend_valid) begin
                            shreg_n      = pend_word;
                            bitcnt_n     = '0;
                            pend_valid_n = 1'b0;
                        end else if (xfer) begin
                            // Word arriving on the final tick is used directly, no pending cycle.
                            shreg_n  = din;
                            bitcnt_n = '0;
                        end else begin
                            state_n  = IDLE;
                            bitcnt_n = '0;
                            strobe_n = 1'b0;
                            done_n   = 1'b1;
                        end
                    end else if (xfer) begin
                        pend_word_n  = din;
                        pend_valid_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            div_reg    <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
            pre_cnt    <= '0;
`endif
        end else begin
            cnt        <= cnt_n;
            div_reg    <= div_reg_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            pend_word  <= pend_word_n;
            pend_valid <= pend_valid_n;
            bit_strobe <= strobe_n;
            frame_done <= done_n;
`ifdef MOD_BIT_SEQUENCER_PREAMBLE_EN
            pre_cnt    <= pre_cnt_n;
`endif
        end
    end

endmodule
